// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared types and helpers for the instruction fetch front end.
//   if_state_e  : fetch FSM encoding (IDLE / WAIT / DROP)
//   iq_entry_t  : one buffered instruction word together with its PC
//   align_pc    : forces a redirect target onto a word boundary
//   next_pc     : sequential (predict-not-taken) successor of a fetch PC
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

    localparam int          IQ_SIZE_DEF = 8;
    localparam logic [31:0] PC_STEP     = 32'd4;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_DROP = 2'b10
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // Wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_fifo
// Circular buffer of fetched instruction words with occupancy count.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   en_in            : global enable; 0 freezes pointers, count and storage
//   flush_in         : empties the queue; overrides push and pop
//   push_in          : write push_entry_in at the tail (caller guarantees room)
//   push_entry_in    : entry to write
//   pop_in           : drop the head entry; ignored when empty
//   head_entry_out   : current head entry, all-zero when the queue is empty
//   count_out        : number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module inst_fetch_queue_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IQ_SIZE_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  iq_entry_t        push_entry_in,
    input  logic             pop_in,
    output iq_entry_t        head_entry_out,
    output logic [CNT_W-1:0] count_out
);

    iq_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    iq_entry_t        head_entry_s;

    // Qualify push/pop with enable and flush; a pop on an empty queue is a no-op.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (en_in && !flush_in) begin
            push_ok_s = push_in;
            pop_ok_s  = pop_in && (count_r != {CNT_W{1'b0}});
        end else begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (en_in && flush_in) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (en_in) begin
            if (push_ok_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_ok_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end else begin
            head_r  <= head_r;
            tail_r  <= tail_r;
            count_r <= count_r;
        end
    end

    // Entry storage; contents are don't-care until written because the head is masked when empty.
    always_ff @(posedge clk_in) begin
        if (push_ok_s) begin
            mem_r[tail_r] <= push_entry_in;
        end
    end

    // Present the head, forced to zero while the queue holds nothing.
    always_comb begin
        head_entry_s = iq_entry_t'(64'd0);
        if (count_r != {CNT_W{1'b0}}) begin
            head_entry_s = mem_r[head_r];
        end else begin
            head_entry_s = iq_entry_t'(64'd0);
        end
    end

    assign head_entry_out = head_entry_s;
    assign count_out      = count_r;

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Fetch front end: owns the fetch PC, keeps at most one instruction read in
// flight to memory and buffers returned words with their PCs for decode.
// Static predict-not-taken; a redirect replaces the fetch PC and flushes.
//   clk_in, rst_n_in       : clock, asynchronous active-low reset
//   rdy_in                 : global enable; 0 freezes all state
//   redirect_in/_pc_in     : resolved control-flow change and its target
//   mem_req_out/_addr_out  : read request and address (= fetch PC)
//   mem_ack_in             : memory accepted the request
//   mem_resp_valid_in/data : read data returned
//   inst_valid_out/inst_out/inst_pc_out : queue head towards decode
//   inst_ready_in          : decode pops the head when valid & ready
// -----------------------------------------------------------------------------
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          IQ_SIZE  = IQ_SIZE_DEF,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic        mem_resp_valid_in,
    input  logic [31:0] mem_resp_data_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_out,
    input  logic        inst_ready_in
);

    localparam int CNT_W = $clog2(IQ_SIZE) + 1;

    if_state_e        state_r;
    logic [31:0]      fetch_pc_r;
    logic [CNT_W-1:0] count_s;
    logic             mem_req_s;
    logic             push_s;
    logic             pop_s;
    iq_entry_t        push_entry_s;
    iq_entry_t        head_entry_s;

    // Request only from IDLE with a reserved slot, so every response has room.
    // Held low during reset and during a redirect cycle (the PC is about to change).
    always_comb begin
        mem_req_s = 1'b0;
        if (rst_n_in && (state_r == IF_IDLE) && (count_s < CNT_W'(IQ_SIZE)) && !redirect_in) begin
            mem_req_s = 1'b1;
        end else begin
            mem_req_s = 1'b0;
        end
    end

    // Queue control: a redirect suppresses both the push and the pop of its cycle.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        push_entry_s = '{pc: fetch_pc_r, inst: mem_resp_data_in};
        if (redirect_in) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = (state_r == IF_WAIT) && mem_resp_valid_in;
            pop_s  = inst_ready_in;
        end
    end

    // Fetch FSM and fetch PC; redirect outranks everything but reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= IF_IDLE;
            fetch_pc_r <= RESET_PC;
        end else if (!rdy_in) begin
            state_r    <= state_r;
            fetch_pc_r <= fetch_pc_r;
        end else if (redirect_in) begin
            fetch_pc_r <= align_pc(redirect_pc_in);
            case (state_r)
                IF_IDLE: state_r <= IF_IDLE;
                // A response landing with the redirect is stale and retires the request.
                IF_WAIT: state_r <= mem_resp_valid_in ? IF_IDLE : IF_DROP;
                IF_DROP: state_r <= mem_resp_valid_in ? IF_IDLE : IF_DROP;
                default: state_r <= IF_IDLE;
            endcase
        end else begin
            case (state_r)
                IF_IDLE: begin
                    if (mem_req_s && mem_ack_in) begin
                        state_r <= IF_WAIT;
                    end else begin
                        state_r <= IF_IDLE;
                    end
                end
                IF_WAIT: begin
                    if (mem_resp_valid_in) begin
                        fetch_pc_r <= next_pc(fetch_pc_r);
                        state_r    <= IF_IDLE;
                    end else begin
                        state_r    <= IF_WAIT;
                    end
                end
                IF_DROP: begin
                    if (mem_resp_valid_in) begin
                        state_r <= IF_IDLE;
                    end else begin
                        state_r <= IF_DROP;
                    end
                end
                default: state_r <= IF_IDLE;
            endcase
        end
    end

    inst_fetch_queue_fifo #(
        .DEPTH          (IQ_SIZE)
    ) u_fifo (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .en_in          (rdy_in),
        .flush_in       (redirect_in),
        .push_in        (push_s),
        .push_entry_in  (push_entry_s),
        .pop_in         (pop_s),
        .head_entry_out (head_entry_s),
        .count_out      (count_s)
    );

    assign mem_req_out    = mem_req_s;
    assign mem_addr_out   = fetch_pc_r;
    assign inst_valid_out = (count_s != {CNT_W{1'b0}});
    assign inst_out       = head_entry_s.inst;
    assign inst_pc_out    = head_entry_s.pc;

endmodule
